rvh_l1d_req_arb: RTL and testbench

Arbiter and sequencer in front of the L1D request decoder. It shares the single L1D pipeline entry port between three requesters: the load pipe, the store pipe and the PTW. It registers the winning request in a one-entry output stage with valid/ready handshakes. It serialises AMO/LR/SC store opcodes by blocking new grants until the AMO completes.

---
 rtl/rvh_l1d_req_arb.sv | 151 +++++++++++++++
 tb/tb_rvh_l1d_req_arb.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvh_l1d_req_arb.sv
// L1D request arbiter: shares the pipeline entry port between load, store and PTW,
// registers the winner in a one-entry output stage and serialises AMO/LR/SC stores.
module rvh_l1d_req_arb #(
    parameter int LDU_OP_WIDTH   = 3,
    parameter int STU_OP_WIDTH   = 5,
    parameter int ADDR_WIDTH     = 40,
    parameter int DATA_WIDTH     = 64,
    parameter int ID_WIDTH       = 5,
    parameter int PTW_STARVE_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ld_req_vld_i,
    output logic                    ld_req_rdy_o,
    input  logic [LDU_OP_WIDTH-1:0] ld_req_opcode_i,
    input  logic [ADDR_WIDTH-1:0]   ld_req_addr_i,
    input  logic [ID_WIDTH-1:0]     ld_req_id_i,
    input  logic                    st_req_vld_i,
    output logic                    st_req_rdy_o,
    input  logic [STU_OP_WIDTH-1:0] st_req_opcode_i,
    input  logic [ADDR_WIDTH-1:0]   st_req_addr_i,
    input  logic [DATA_WIDTH-1:0]   st_req_data_i,
    input  logic [ID_WIDTH-1:0]     st_req_id_i,
    input  logic                    ptw_req_vld_i,
    output logic                    ptw_req_rdy_o,
    input  logic [ADDR_WIDTH-1:0]   ptw_req_addr_i,
    output logic                    l1d_req_vld_o,
    input  logic                    l1d_req_rdy_i,
    output logic [1:0]              l1d_req_src_o,
    output logic [LDU_OP_WIDTH-1:0] l1d_req_ld_opcode_o,
    output logic [STU_OP_WIDTH-1:0] l1d_req_st_opcode_o,
    output logic [ADDR_WIDTH-1:0]   l1d_req_addr_o,
    output logic [DATA_WIDTH-1:0]   l1d_req_data_o,
    output logic [ID_WIDTH-1:0]     l1d_req_id_o,
    input  logic                    amo_done_i,
    input  logic                    flush_i,
    output logic                    illegal_req_o,
    output logic                    amo_busy_o
);
    localparam int CW = $clog2(PTW_STARVE_MAX + 1);
    localparam logic [1:0] SRC_LD  = 2'd0;
    localparam logic [1:0] SRC_ST  = 2'd1;
    localparam logic [1:0] SRC_PTW = 2'd2;

    typedef enum logic {S_NORMAL, S_AMO_WAIT} state_t;

    state_t        state;
    logic          rr_st;
    logic [CW-1:0] starve_cnt;

    logic ld_v, st_v, out_free, can_grant, starved;
    logic gnt_ld, gnt_st, gnt_ptw;
    logic ld_illegal, st_illegal, st_amo;

    // A flushed load is invisible to arbitration, so it cannot block PTW via starvation.
    assign ld_v      = ld_req_vld_i & ~flush_i;
    assign st_v      = st_req_vld_i;
    assign out_free  = ~l1d_req_vld_o | l1d_req_rdy_i;
    assign can_grant = out_free & (state == S_NORMAL);
    assign starved   = (starve_cnt == CW'(PTW_STARVE_MAX)) & (ld_v | st_v);

    assign ld_illegal = (ld_req_opcode_i == LDU_OP_WIDTH'(7));
    assign st_illegal = ((st_req_opcode_i >= STU_OP_WIDTH'(4)) & (st_req_opcode_i <= STU_OP_WIDTH'(6)))
                      | (st_req_opcode_i >= STU_OP_WIDTH'(29));
    assign st_amo     = (st_req_opcode_i >= STU_OP_WIDTH'(11)) & (st_req_opcode_i <= STU_OP_WIDTH'(28));

    always_comb begin
        gnt_ld  = 1'b0;
        gnt_st  = 1'b0;
        gnt_ptw = 1'b0;
        if (can_grant) begin
            if (ptw_req_vld_i & ~starved) begin
                gnt_ptw = 1'b1;
            end else if (ld_v & st_v) begin
                gnt_st = rr_st;
                gnt_ld = ~rr_st;
            end else begin
                gnt_ld = ld_v;
                gnt_st = st_v;
            end
        end
    end

    assign ld_req_rdy_o  = gnt_ld;
    assign st_req_rdy_o  = gnt_st;
    assign ptw_req_rdy_o = gnt_ptw;
    assign amo_busy_o    = (state == S_AMO_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= S_NORMAL;
            rr_st               <= 1'b0;
            starve_cnt          <= '0;
            illegal_req_o       <= 1'b0;
            l1d_req_vld_o       <= 1'b0;
            l1d_req_src_o       <= '0;
            l1d_req_ld_opcode_o <= '0;
            l1d_req_st_opcode_o <= '0;
            l1d_req_addr_o      <= '0;
            l1d_req_data_o      <= '0;
            l1d_req_id_o        <= '0;
        end else begin
            illegal_req_o <= (gnt_ld & ld_illegal) | (gnt_st & st_illegal);

            if (gnt_ld | gnt_st) begin
                rr_st <= gnt_ld;
            end

            if (gnt_ld | gnt_st | ~(ld_v | st_v)) begin
                starve_cnt <= '0;
            end else if (gnt_ptw && (starve_cnt != CW'(PTW_STARVE_MAX))) begin
                starve_cnt <= starve_cnt + CW'(1);
            end

            case (state)
                S_NORMAL:   if (gnt_st & st_amo) state <= S_AMO_WAIT;
                S_AMO_WAIT: if (amo_done_i) state <= S_NORMAL;
                default:    state <= S_NORMAL;
            endcase

            // Grants only happen when the stage is free, so a load always replaces or refills.
            if (gnt_ld & ~ld_illegal) begin
                l1d_req_vld_o       <= 1'b1;
                l1d_req_src_o       <= SRC_LD;
                l1d_req_ld_opcode_o <= ld_req_opcode_i;
                l1d_req_st_opcode_o <= '0;
                l1d_req_addr_o      <= ld_req_addr_i;
                l1d_req_data_o      <= '0;
                l1d_req_id_o        <= ld_req_id_i;
            end else if (gnt_st & ~st_illegal) begin
                l1d_req_vld_o       <= 1'b1;
                l1d_req_src_o       <= SRC_ST;
                l1d_req_ld_opcode_o <= '0;
                l1d_req_st_opcode_o <= st_req_opcode_i;
                l1d_req_addr_o      <= st_req_addr_i;
                l1d_req_data_o      <= st_req_data_i;
                l1d_req_id_o        <= st_req_id_i;
            end else if (gnt_ptw) begin
                l1d_req_vld_o       <= 1'b1;
                l1d_req_src_o       <= SRC_PTW;
                l1d_req_ld_opcode_o <= '0;
                l1d_req_st_opcode_o <= '0;
                l1d_req_addr_o      <= ptw_req_addr_i;
                l1d_req_data_o      <= '0;
                l1d_req_id_o        <= '0;
            end else if (l1d_req_vld_o & (l1d_req_rdy_i | (flush_i & (l1d_req_src_o == SRC_LD)))) begin
                l1d_req_vld_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rvh_l1d_req_arb.sv
// Self-checking bench for rvh_l1d_req_arb: directed scenarios plus random traffic
// checked against a queue-based model of the arbitration rules.
module tb_rvh_l1d_req_arb;
    localparam int LW = 3;
    localparam int SW = 5;
    localparam int AW = 40;
    localparam int DW = 64;
    localparam int IW = 5;
    localparam int STARVE = 4;
    localparam int EW = 2 + LW + SW + AW + DW + IW;
    localparam int OW = 1 + EW + 2;
    localparam int W_NONE = 0, W_LD = 1, W_ST = 2, W_PTW = 3;

    logic clk = 1'b0;
    logic rst;
    logic ld_req_vld_i, ld_req_rdy_o;
    logic [LW-1:0] ld_req_opcode_i;
    logic [AW-1:0] ld_req_addr_i;
    logic [IW-1:0] ld_req_id_i;
    logic st_req_vld_i, st_req_rdy_o;
    logic [SW-1:0] st_req_opcode_i;
    logic [AW-1:0] st_req_addr_i;
    logic [DW-1:0] st_req_data_i;
    logic [IW-1:0] st_req_id_i;
    logic ptw_req_vld_i, ptw_req_rdy_o;
    logic [AW-1:0] ptw_req_addr_i;
    logic l1d_req_vld_o, l1d_req_rdy_i;
    logic [1:0] l1d_req_src_o;
    logic [LW-1:0] l1d_req_ld_opcode_o;
    logic [SW-1:0] l1d_req_st_opcode_o;
    logic [AW-1:0] l1d_req_addr_o;
    logic [DW-1:0] l1d_req_data_o;
    logic [IW-1:0] l1d_req_id_o;
    logic amo_done_i, flush_i, illegal_req_o, amo_busy_o;

    rvh_l1d_req_arb #(
        .LDU_OP_WIDTH(LW), .STU_OP_WIDTH(SW), .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW), .ID_WIDTH(IW), .PTW_STARVE_MAX(STARVE)
    ) dut (
        .clk(clk), .rst(rst),
        .ld_req_vld_i(ld_req_vld_i), .ld_req_rdy_o(ld_req_rdy_o),
        .ld_req_opcode_i(ld_req_opcode_i), .ld_req_addr_i(ld_req_addr_i), .ld_req_id_i(ld_req_id_i),
        .st_req_vld_i(st_req_vld_i), .st_req_rdy_o(st_req_rdy_o),
        .st_req_opcode_i(st_req_opcode_i), .st_req_addr_i(st_req_addr_i),
        .st_req_data_i(st_req_data_i), .st_req_id_i(st_req_id_i),
        .ptw_req_vld_i(ptw_req_vld_i), .ptw_req_rdy_o(ptw_req_rdy_o), .ptw_req_addr_i(ptw_req_addr_i),
        .l1d_req_vld_o(l1d_req_vld_o), .l1d_req_rdy_i(l1d_req_rdy_i), .l1d_req_src_o(l1d_req_src_o),
        .l1d_req_ld_opcode_o(l1d_req_ld_opcode_o), .l1d_req_st_opcode_o(l1d_req_st_opcode_o),
        .l1d_req_addr_o(l1d_req_addr_o), .l1d_req_data_o(l1d_req_data_o), .l1d_req_id_o(l1d_req_id_o),
        .amo_done_i(amo_done_i), .flush_i(flush_i),
        .illegal_req_o(illegal_req_o), .amo_busy_o(amo_busy_o)
    );

    always #5 clk = ~clk;

    // Model: the output stage is a queue of at most one entry.
    logic [EW-1:0] exp_q[$];
    bit m_busy, m_ld_turn, m_ill, m_ldv, m_stv;
    int m_cnt, m_win;
    logic [2:0] exp_rdy, act_rdy;
    logic [OW-1:0] exp_o, act_o;
    int n_checks = 0;
    int n_fail = 0;

    task automatic set_idle();
        ld_req_vld_i = 0; ld_req_opcode_i = '0; ld_req_addr_i = '0; ld_req_id_i = '0;
        st_req_vld_i = 0; st_req_opcode_i = '0; st_req_addr_i = '0; st_req_data_i = '0; st_req_id_i = '0;
        ptw_req_vld_i = 0; ptw_req_addr_i = '0;
        l1d_req_rdy_i = 1; amo_done_i = 0; flush_i = 0;
    endtask

    task automatic model_reset();
        exp_q.delete(); m_busy = 0; m_ld_turn = 1; m_ill = 0; m_cnt = 0;
    endtask

    // One clock: predict the grant from the rules, sample rdy, then advance the model.
    task automatic tick();
        bit free, ill, have, amo_now;
        logic [EW-1:0] ent, head;
        @(negedge clk);
        free = (exp_q.size() == 0) || l1d_req_rdy_i;
        m_ldv = ld_req_vld_i && !flush_i;
        m_stv = st_req_vld_i;
        m_win = W_NONE;
        if (!rst && free && !m_busy) begin
            if (ptw_req_vld_i && !(m_cnt == STARVE && (m_ldv || m_stv))) m_win = W_PTW;
            else if (m_ldv && (!m_stv || m_ld_turn)) m_win = W_LD;
            else if (m_stv) m_win = W_ST;
        end
        exp_rdy = {m_win == W_PTW, m_win == W_ST, m_win == W_LD};
        act_rdy = {ptw_req_rdy_o, st_req_rdy_o, ld_req_rdy_o};
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            ill = 0; have = 0; amo_now = 0; ent = '0;
            if (m_win == W_LD) begin
                m_ld_turn = 0;
                if (ld_req_opcode_i == 3'd7) ill = 1;
                else begin have = 1; ent = {2'd0, ld_req_opcode_i, 5'd0, ld_req_addr_i, 64'd0, ld_req_id_i}; end
            end else if (m_win == W_ST) begin
                m_ld_turn = 1;
                if (st_req_opcode_i inside {[5'd4:5'd6], [5'd29:5'd31]}) ill = 1;
                else begin
                    have = 1;
                    ent = {2'd1, 3'd0, st_req_opcode_i, st_req_addr_i, st_req_data_i, st_req_id_i};
                    amo_now = st_req_opcode_i inside {[5'd11:5'd28]};
                end
            end else if (m_win == W_PTW) begin
                have = 1; ent = {2'd2, 3'd0, 5'd0, ptw_req_addr_i, 64'd0, 5'd0};
            end
            if (exp_q.size() != 0) begin
                head = exp_q[0];
                if (l1d_req_rdy_i || (flush_i && head[EW-1 -: 2] == 2'd0)) void'(exp_q.pop_front());
            end
            if (have) exp_q.push_back(ent);
            if (m_win == W_LD || m_win == W_ST || !(m_ldv || m_stv)) m_cnt = 0;
            else if (m_win == W_PTW) m_cnt = (m_cnt < STARVE) ? m_cnt + 1 : STARVE;
            if (m_busy) begin
                if (amo_done_i) m_busy = 0;
            end else if (amo_now) begin
                m_busy = 1;
            end
            m_ill = ill;
        end
        #1;
        exp_o = {exp_q.size() != 0, (exp_q.size() != 0) ? exp_q[0] : {EW{1'b0}}, m_ill, m_busy};
        act_o = {l1d_req_vld_o,
                 l1d_req_vld_o ? {l1d_req_src_o, l1d_req_ld_opcode_o, l1d_req_st_opcode_o,
                                  l1d_req_addr_o, l1d_req_data_o, l1d_req_id_o} : {EW{1'b0}},
                 illegal_req_o, amo_busy_o};
    endtask

    task automatic test_reset();
        set_idle(); rst = 1;
        tick(); tick();
        n_checks++;
        if (act_o !== {OW{1'b0}}) begin n_fail++; $display("FAIL reset_outputs act=%h exp=0", act_o); end
        n_checks++;
        if (act_rdy !== 3'b000) begin n_fail++; $display("FAIL reset_rdy act=%b exp=000", act_rdy); end
        rst = 0;
        tick();
        n_checks++;
        if (act_o !== exp_o) begin n_fail++; $display("FAIL post_reset act=%h exp=%h", act_o, exp_o); end
    endtask

    task automatic test_round_robin();
        set_idle();
        ld_req_vld_i = 1; ld_req_addr_i = 40'h100; ld_req_id_i = 5'd1;
        st_req_vld_i = 1; st_req_addr_i = 40'h200; st_req_data_i = 64'hdead_beef; st_req_id_i = 5'd2;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (act_rdy !== exp_rdy) begin n_fail++; $display("FAIL rr_rdy[%0d] act=%b exp=%b", i, act_rdy, exp_rdy); end
            n_checks++;
            if (l1d_req_src_o !== 2'(i % 2) || l1d_req_addr_o !== ((i % 2) ? 40'h200 : 40'h100)) begin
                n_fail++; $display("FAIL rr_src[%0d] act_src=%0d act_addr=%h exp_src=%0d", i, l1d_req_src_o, l1d_req_addr_o, i % 2);
            end
            n_checks++;
            if (act_o !== exp_o) begin n_fail++; $display("FAIL rr_out[%0d] act=%h exp=%h", i, act_o, exp_o); end
        end
        set_idle(); tick();
    endtask

    task automatic test_starve();
        int pat[10] = '{2, 2, 2, 2, 0, 2, 2, 2, 2, 1};
        set_idle();
        ld_req_vld_i = 1; ld_req_addr_i = 40'h110;
        st_req_vld_i = 1; st_req_addr_i = 40'h210;
        ptw_req_vld_i = 1; ptw_req_addr_i = 40'h300;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (l1d_req_vld_o !== 1'b1 || l1d_req_src_o !== 2'(pat[i])) begin
                n_fail++; $display("FAIL starve_src[%0d] act=%0d exp=%0d", i, l1d_req_src_o, pat[i]);
            end
            n_checks++;
            if (act_o !== exp_o) begin n_fail++; $display("FAIL starve_out[%0d] act=%h exp=%h", i, act_o, exp_o); end
        end
        set_idle(); tick();
    endtask

    task automatic test_amo();
        set_idle();
        st_req_vld_i = 1; st_req_opcode_i = 5'd11; st_req_addr_i = 40'h400; st_req_id_i = 5'd3;
        tick();
        st_req_vld_i = 0;
        ld_req_vld_i = 1; ld_req_addr_i = 40'h440; ld_req_id_i = 5'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (amo_busy_o !== 1'b1 || act_rdy !== 3'b000) begin
                n_fail++; $display("FAIL amo_block[%0d] busy=%b rdy=%b exp busy=1 rdy=000", i, amo_busy_o, act_rdy);
            end
        end
        amo_done_i = 1;
        tick();
        n_checks++;
        if (act_rdy !== 3'b000 || amo_busy_o !== 1'b0) begin
            n_fail++; $display("FAIL amo_done_cycle rdy=%b busy=%b exp rdy=000 busy=0", act_rdy, amo_busy_o);
        end
        amo_done_i = 0;
        tick();
        n_checks++;
        if (act_rdy !== 3'b001) begin n_fail++; $display("FAIL amo_resume_rdy act=%b exp=001", act_rdy); end
        n_checks++;
        if (l1d_req_vld_o !== 1'b1 || l1d_req_src_o !== 2'd0 || l1d_req_addr_o !== 40'h440) begin
            n_fail++; $display("FAIL amo_resume_out vld=%b src=%0d addr=%h exp vld=1 src=0 addr=440", l1d_req_vld_o, l1d_req_src_o, l1d_req_addr_o);
        end
        n_checks++;
        if (act_o !== exp_o) begin n_fail++; $display("FAIL amo_out act=%h exp=%h", act_o, exp_o); end
        set_idle(); tick();
    endtask

    task automatic test_hold();
        set_idle();
        ld_req_vld_i = 1; ld_req_opcode_i = 3'd2; ld_req_id_i = 5'd7; ld_req_addr_i = 40'h500;
        tick();
        l1d_req_rdy_i = 0;
        ld_req_opcode_i = 3'd3; ld_req_id_i = 5'd9; ld_req_addr_i = 40'h508;
        st_req_vld_i = 1; st_req_addr_i = 40'h580;
        ptw_req_vld_i = 1; ptw_req_addr_i = 40'h5c0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (act_rdy !== 3'b000) begin n_fail++; $display("FAIL hold_rdy[%0d] act=%b exp=000", i, act_rdy); end
            n_checks++;
            if (l1d_req_vld_o !== 1'b1 || l1d_req_ld_opcode_o !== 3'd2 || l1d_req_id_o !== 5'd7 || l1d_req_addr_o !== 40'h500) begin
                n_fail++; $display("FAIL hold_out[%0d] vld=%b op=%0d id=%0d addr=%h exp 1/2/7/500", i, l1d_req_vld_o, l1d_req_ld_opcode_o, l1d_req_id_o, l1d_req_addr_o);
            end
        end
        l1d_req_rdy_i = 1;
        tick();
        n_checks++;
        if (act_rdy !== 3'b100) begin n_fail++; $display("FAIL hold_release_rdy act=%b exp=100", act_rdy); end
        n_checks++;
        if (act_o !== exp_o) begin n_fail++; $display("FAIL hold_release_out act=%h exp=%h", act_o, exp_o); end
        set_idle(); tick();
    endtask

    task automatic test_flush();
        set_idle();
        ld_req_vld_i = 1; ld_req_opcode_i = 3'd1; ld_req_addr_i = 40'h610;
        tick();
        ld_req_vld_i = 0; l1d_req_rdy_i = 0; flush_i = 1;
        st_req_vld_i = 1; st_req_addr_i = 40'h600; st_req_id_i = 5'd5;
        tick();
        n_checks++;
        if (l1d_req_vld_o !== 1'b0) begin n_fail++; $display("FAIL flush_kill vld=%b exp=0", l1d_req_vld_o); end
        flush_i = 0;
        tick();
        n_checks++;
        if (act_rdy !== 3'b010 || l1d_req_vld_o !== 1'b1 || l1d_req_src_o !== 2'd1) begin
            n_fail++; $display("FAIL flush_st rdy=%b vld=%b src=%0d exp rdy=010 vld=1 src=1", act_rdy, l1d_req_vld_o, l1d_req_src_o);
        end
        n_checks++;
        if (act_o !== exp_o) begin n_fail++; $display("FAIL flush_out act=%h exp=%h", act_o, exp_o); end
        set_idle(); tick();
    endtask

    task automatic test_illegal();
        set_idle(); tick();
        st_req_vld_i = 1; st_req_opcode_i = 5'd30;
        tick();
        n_checks++;
        if (act_rdy !== 3'b010 || l1d_req_vld_o !== 1'b0 || illegal_req_o !== 1'b1) begin
            n_fail++; $display("FAIL illegal_st rdy=%b vld=%b ill=%b exp 010/0/1", act_rdy, l1d_req_vld_o, illegal_req_o);
        end
        st_req_vld_i = 0;
        tick();
        n_checks++;
        if (illegal_req_o !== 1'b0) begin n_fail++; $display("FAIL illegal_st_pulse ill=%b exp=0", illegal_req_o); end
        ld_req_vld_i = 1; ld_req_opcode_i = 3'd7;
        tick();
        n_checks++;
        if (act_rdy !== 3'b001 || l1d_req_vld_o !== 1'b0 || illegal_req_o !== 1'b1) begin
            n_fail++; $display("FAIL illegal_ld rdy=%b vld=%b ill=%b exp 001/0/1", act_rdy, l1d_req_vld_o, illegal_req_o);
        end
        ld_req_vld_i = 0;
        tick();
        n_checks++;
        if (illegal_req_o !== 1'b0 || act_o !== exp_o) begin n_fail++; $display("FAIL illegal_ld_pulse act=%h exp=%h", act_o, exp_o); end
    endtask

    task automatic test_reset_mid();
        set_idle();
        st_req_vld_i = 1; st_req_opcode_i = 5'd20; st_req_addr_i = 40'h700;
        l1d_req_rdy_i = 0;
        tick();
        st_req_vld_i = 0;
        tick();
        n_checks++;
        if (amo_busy_o !== 1'b1 || l1d_req_vld_o !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre busy=%b vld=%b exp 1/1", amo_busy_o, l1d_req_vld_o);
        end
        rst = 1;
        tick();
        rst = 0;
        n_checks++;
        if (act_o !== {OW{1'b0}}) begin n_fail++; $display("FAIL mid_reset act=%h exp=0", act_o); end
        set_idle(); tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            ld_req_vld_i = ($urandom_range(0, 1) == 1);
            ld_req_opcode_i = LW'($urandom_range(0, 7));
            ld_req_addr_i = AW'({$urandom(), $urandom()});
            ld_req_id_i = IW'($urandom_range(0, 31));
            st_req_vld_i = ($urandom_range(0, 1) == 1);
            st_req_opcode_i = SW'($urandom_range(0, 31));
            st_req_addr_i = AW'({$urandom(), $urandom()});
            st_req_data_i = {$urandom(), $urandom()};
            st_req_id_i = IW'($urandom_range(0, 31));
            ptw_req_vld_i = ($urandom_range(0, 2) == 0);
            ptw_req_addr_i = AW'({$urandom(), $urandom()});
            l1d_req_rdy_i = ($urandom_range(0, 3) != 0);
            flush_i = ($urandom_range(0, 7) == 0);
            amo_done_i = ($urandom_range(0, 5) == 0);
            tick();
            n_checks++;
            if (act_rdy !== exp_rdy) begin n_fail++; $display("FAIL rand_rdy[%0d] act=%b exp=%b", i, act_rdy, exp_rdy); end
            n_checks++;
            if (act_o !== exp_o) begin n_fail++; $display("FAIL rand_out[%0d] act=%h exp=%h", i, act_o, exp_o); end
        end
        set_idle(); tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_round_robin();
        test_starve();
        test_amo();
        test_hold();
        test_flush();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
